// File: rtl/vid_tim_det.sv
// -----------------------------------------------------------------------------
// vid_tim_det
//
// Timing detector for the trigger-driven video timing generator. Samples an
// incoming hsync/vsync/daten triplet and measures hsync pulse width, line
// period, active (daten) length and lines per frame. Widths and periods are
// reported as "count minus one", the same encoding the generator uses for its
// Thsync/Thlen registers, so readings compare directly against programmed
// values. Lock is raised once consecutive lines match; mismatches and missing
// hsync are flagged.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   ena          clock enable; sampling and counting advance only when 1
//   hsync_in     incoming line sync, active high
//   vsync_in     incoming frame sync, active high
//   daten_in     incoming data enable
//   meas_hsync   hsync high samples minus 1 (saturating)
//   meas_hlen    hsync rise-to-rise samples minus 1
//   meas_active  daten-high samples in the previous line
//   meas_vlines  hsync rises between consecutive vsync rises
//   meas_vld     1-clk pulse: meas_hsync/hlen/active updated
//   frame_start  1-clk pulse: vsync rise seen, meas_vlines updated
//   lock         level: line timing stable
//   err          1-clk pulse: line measurement mismatch while tracking
//   timeout      level: no hsync rise within 2^LEN_W-1 samples
// -----------------------------------------------------------------------------
module vid_tim_det #(
    parameter int HW_W     = 8,
    parameter int LEN_W    = 16,
    parameter int LINE_W   = 12,
    parameter int LOCK_CNT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              daten_in,
    output logic [HW_W-1:0]   meas_hsync,
    output logic [LEN_W-1:0]  meas_hlen,
    output logic [LEN_W-1:0]  meas_active,
    output logic [LINE_W-1:0] meas_vlines,
    output logic              meas_vld,
    output logic              frame_start,
    output logic              lock,
    output logic              err,
    output logic              timeout
);

    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_LAST = LEN_MAX - LEN_ONE;
    localparam logic [HW_W-1:0]   HW_MAX   = '1;
    localparam logic [HW_W-1:0]   HW_ONE   = HW_W'(1);
    localparam logic [LINE_W-1:0] LINE_MAX = '1;
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
    localparam logic [3:0]        LOCK_TGT = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_FIRST  = 2'd1,
        ST_TRACK  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Input sampling. Bit 0 = hsync, bit 1 = vsync; both need edge detection,
    // so each keeps a current and previous sample.
    // -------------------------------------------------------------------------
    logic [1:0] sync_pin;
    logic [1:0] sync_cur;
    logic [1:0] sync_prev;

    assign sync_pin = {vsync_in, hsync_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic cur_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cur_reg  <= 1'b0;
                    prev_reg <= 1'b0;
                end else if (ena) begin
                    prev_reg <= cur_reg;
                    cur_reg  <= sync_pin[gi];
                end
            end

            assign sync_cur[gi]  = cur_reg;
            assign sync_prev[gi] = prev_reg;
        end
    endgenerate

    logic daten_cur_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            daten_cur_reg <= 1'b0;
        end else if (ena) begin
            daten_cur_reg <= daten_in;
        end
    end

    logic hs_cur;
    logic hs_rise;
    logic hs_fall;
    logic vs_rise;

    assign hs_cur  = sync_cur[0];
    assign hs_rise = sync_cur[0] & ~sync_prev[0];
    assign hs_fall = ~sync_cur[0] & sync_prev[0];
    assign vs_rise = sync_cur[1] & ~sync_prev[1];

    // -------------------------------------------------------------------------
    // Measurement state
    // -------------------------------------------------------------------------
    state_t              state_reg;
    logic [LEN_W-1:0]    cnt_per_reg;
    logic [HW_W-1:0]     cnt_hi_reg;
    logic [LEN_W-1:0]    cnt_act_reg;
    logic [HW_W-1:0]     hs_w_reg;
    logic [LEN_W-1:0]    ref_hlen_reg;
    logic [HW_W-1:0]     ref_hsync_reg;
    logic [3:0]          match_cnt_reg;
    logic [LINE_W-1:0]   line_cnt_reg;

    logic [3:0] match_next;
    logic       line_match;
    logic       line_done;
    logic       per_expire;

    // Saturating match counter; lock follows the value being written so that
    // the line which makes match_cnt reach LOCK_CNT is the one that locks.
    assign match_next = (match_cnt_reg == LOCK_TGT) ? match_cnt_reg
                                                    : match_cnt_reg + 4'd1;
    assign line_match = (cnt_per_reg == ref_hlen_reg) && (hs_w_reg == ref_hsync_reg);
    // A completed line is only reported once a reference rise has been seen.
    assign line_done  = hs_rise && (state_reg != ST_SEARCH);
    // Fires on the sample where cnt_per steps onto all-ones.
    assign per_expire = !hs_rise && (cnt_per_reg == LEN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_SEARCH;
            cnt_per_reg   <= '0;
            cnt_hi_reg    <= '0;
            cnt_act_reg   <= '0;
            hs_w_reg      <= '0;
            ref_hlen_reg  <= '0;
            ref_hsync_reg <= '0;
            match_cnt_reg <= '0;
            line_cnt_reg  <= '0;
            meas_hsync    <= '0;
            meas_hlen     <= '0;
            meas_active   <= '0;
            meas_vlines   <= '0;
            meas_vld      <= 1'b0;
            frame_start   <= 1'b0;
            lock          <= 1'b0;
            err           <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            meas_vld    <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;

            if (ena) begin
                // Per-line counters restart on the rise sample itself; a daten
                // sample coinciding with the rise belongs to the new line.
                if (hs_rise) begin
                    cnt_per_reg <= '0;
                    cnt_hi_reg  <= '0;
                    cnt_act_reg <= daten_cur_reg ? LEN_ONE : '0;
                end else begin
                    if (cnt_per_reg != LEN_MAX) begin
                        cnt_per_reg <= cnt_per_reg + LEN_ONE;
                    end
                    if (hs_cur && (cnt_hi_reg != HW_MAX)) begin
                        cnt_hi_reg <= cnt_hi_reg + HW_ONE;
                    end
                    if (daten_cur_reg && (cnt_act_reg != LEN_MAX)) begin
                        cnt_act_reg <= cnt_act_reg + LEN_ONE;
                    end
                end

                if (hs_fall) begin
                    hs_w_reg <= cnt_hi_reg;
                end

                // Frame counting. A line whose hsync rise coincides with the
                // vsync rise is the first line of the new frame.
                if (vs_rise) begin
                    meas_vlines  <= line_cnt_reg;
                    frame_start  <= 1'b1;
                    line_cnt_reg <= hs_rise ? LINE_ONE : '0;
                end else if (hs_rise && (line_cnt_reg != LINE_MAX)) begin
                    line_cnt_reg <= line_cnt_reg + LINE_ONE;
                end

                if (line_done) begin
                    meas_hlen   <= cnt_per_reg;
                    meas_hsync  <= hs_w_reg;
                    meas_active <= cnt_act_reg;
                    meas_vld    <= 1'b1;
                end

                if (hs_rise) begin
                    timeout <= 1'b0;
                end

                case (state_reg)
                    ST_SEARCH: begin
                        if (hs_rise) begin
                            state_reg <= ST_FIRST;
                        end
                    end
                    ST_FIRST: begin
                        if (hs_rise) begin
                            ref_hlen_reg  <= cnt_per_reg;
                            ref_hsync_reg <= hs_w_reg;
                            match_cnt_reg <= '0;
                            state_reg     <= ST_TRACK;
                        end else if (per_expire) begin
                            timeout   <= 1'b1;
                            lock      <= 1'b0;
                            state_reg <= ST_SEARCH;
                        end
                    end
                    ST_TRACK: begin
                        if (hs_rise) begin
                            if (line_match) begin
                                match_cnt_reg <= match_next;
                                if (match_next == LOCK_TGT) begin
                                    lock <= 1'b1;
                                end
                            end else begin
                                // Re-seed the reference from the new timing.
                                err           <= 1'b1;
                                lock          <= 1'b0;
                                ref_hlen_reg  <= cnt_per_reg;
                                ref_hsync_reg <= hs_w_reg;
                                match_cnt_reg <= '0;
                            end
                        end else if (per_expire) begin
                            timeout   <= 1'b1;
                            lock      <= 1'b0;
                            state_reg <= ST_SEARCH;
                        end
                    end
                    default: begin
                        state_reg <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

endmodule
